// File: rtl/spram_arb_pkg.sv
// Shared types and sizes for the single-port SRAM arbiter/sequencer.
// Optional round-robin arbitration is enabled with SPRAM_ARB_RR_EN (see spram_arb_2to1).
package spram_arb_pkg;

    localparam int unsigned SPRAM_ADDR_W = 6;
    localparam int unsigned SPRAM_DATA_W = 32;
    localparam int unsigned SPRAM_DEPTH  = 64;

    typedef enum logic [0:0] {
        INIT,
        RUN
    } arb_state_e;

    typedef struct packed {
        logic                    we;
        logic [SPRAM_ADDR_W-1:0] addr;
        logic [SPRAM_DATA_W-1:0] wdata;
    } arb_req_t;

endpackage

// File: rtl/spram_arb_2to1.sv
// Two-way combinational grant logic. Fixed priority (requester 0 wins) by default;
// define SPRAM_ARB_RR_EN for round-robin on contention with an rr_ptr flop.
module spram_arb_2to1 (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1
);

`ifdef SPRAM_ARB_RR_EN
    // rr_ptr names the preferred requester; it moves to the loser after each contended grant.
    logic rr_ptr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr <= 1'b0;
        end else if (en && req0 && req1) begin
            rr_ptr <= ~rr_ptr;
        end
    end

    always_comb begin
        gnt0 = en & req0 & (~req1 | ~rr_ptr);
        gnt1 = en & req1 & (~req0 | rr_ptr);
    end
`else
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;

    always_comb begin
        gnt0 = en & req0;
        gnt1 = en & req1 & ~req0;
    end
`endif

endmodule

// File: rtl/spram_arb_ctrl.sv
// Clears a 64x32 single-port SRAM after reset, then arbitrates it between two requesters.
// Arbitration policy selected by SPRAM_ARB_RR_EN (round-robin) or fixed priority when undefined.
module spram_arb_ctrl
    import spram_arb_pkg::*;
#(
    parameter int unsigned      ADDR_W   = SPRAM_ADDR_W,
    parameter int unsigned      DATA_W   = SPRAM_DATA_W,
    parameter int unsigned      DEPTH    = SPRAM_DEPTH,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              init_done,
    output logic              mem_ceb,
    output logic              mem_web,
    output logic [ADDR_W-1:0] mem_a,
    output logic [DATA_W-1:0] mem_d,
    input  logic [DATA_W-1:0] mem_q
);

    arb_state_e        state;
    logic [ADDR_W-1:0] init_cnt;
    logic [ADDR_W-1:0] a_hold;
    logic [DATA_W-1:0] d_hold;
    arb_req_t          req_w;
    logic              run;

    assign run = (state == RUN);

    spram_arb_2to1 u_arb (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (run),
        .req0 (req0),
        .req1 (req1),
        .gnt0 (gnt0),
        .gnt1 (gnt1)
    );

    always_comb begin
        req_w.we    = gnt1 ? we1 : we0;
        req_w.addr  = gnt1 ? addr1 : addr0;
        req_w.wdata = gnt1 ? wdata1 : wdata0;
    end

    // Idle cycles keep address/data at their last values so the macro pins don't toggle.
    always_comb begin
        mem_ceb = 1'b1;
        mem_web = 1'b1;
        mem_a   = a_hold;
        mem_d   = d_hold;
        if (!run) begin
            mem_ceb = 1'b0;
            mem_web = 1'b0;
            mem_a   = init_cnt;
            mem_d   = INIT_VAL;
        end else if (gnt0 || gnt1) begin
            mem_ceb = 1'b0;
            mem_web = ~req_w.we;
            mem_a   = req_w.addr;
            mem_d   = req_w.wdata;
        end
    end

    assign rdata0 = mem_q;
    assign rdata1 = mem_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= INIT;
            init_cnt  <= '0;
            init_done <= 1'b0;
            rvalid0   <= 1'b0;
            rvalid1   <= 1'b0;
            a_hold    <= '0;
            d_hold    <= '0;
        end else begin
            a_hold  <= mem_a;
            d_hold  <= mem_d;
            rvalid0 <= gnt0 & ~we0;
            rvalid1 <= gnt1 & ~we1;
            case (state)
                INIT: begin
                    init_cnt <= init_cnt + 1'b1;
                    if (init_cnt == ADDR_W'(DEPTH - 1)) begin
                        state     <= RUN;
                        init_done <= 1'b1;
                    end
                end
                RUN:     state <= RUN;
                default: state <= INIT;
            endcase
        end
    end

endmodule
